// File: rtl/backoff_retry_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | backoff_retry_ctrl_pkg                                                   |
// | Shared FSM encoding and retry-counter sizing for backoff_retry_ctrl.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package backoff_retry_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        BACKOFF  = 2'd3
    } state_e;

    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_ISSUE    = ISSUE;
    localparam logic [1:0] ST_WAIT_RSP = WAIT_RSP;
    localparam logic [1:0] ST_BACKOFF  = BACKOFF;

    // Width of the failed-attempt counter; never narrower than one bit.
    function automatic int unsigned retries_width(input int unsigned max_retries);
        int unsigned w;
        w = $clog2(max_retries + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/backoff_retry_ctrl_exp_backoff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | exp_backoff                                                              |
// | Randomized exponential backoff counter: 16-bit LFSR masked by a growing  |
// | run of ones, reloaded on set_i and cleared on clr_i.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module exp_backoff #(
    parameter int unsigned Seed   = 'hffff,
    parameter int unsigned MaxExp = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic set_i,
    input  logic clr_i,
    output logic is_zero_o
);

    localparam int unsigned WIDTH = 16;
    localparam logic [WIDTH-1:0] C_MASK_CAP = WIDTH'((64'd1 << MaxExp) - 64'd1);

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cnt;
    logic             w_fb;

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR
    assign w_fb      = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign is_zero_o = (r_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr <= WIDTH'(Seed);
            r_mask <= '0;
            r_cnt  <= '0;
        end else begin
            if (set_i) begin
                r_lfsr <= {w_fb, r_lfsr[WIDTH-1:1]};
            end
            // The wait uses the mask from before this set, so the first retry waits 0
            if (clr_i) begin
                r_mask <= '0;
                r_cnt  <= '0;
            end else if (set_i) begin
                r_mask <= {r_mask[WIDTH-2:0], 1'b1} & C_MASK_CAP;
                r_cnt  <= r_mask & r_lfsr;
            end else if (!is_zero_o) begin
                r_cnt  <= r_cnt - WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/backoff_retry_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | backoff_retry_ctrl                                                       |
// | Issues one request downstream, retries failures with exponential backoff |
// | and reports completion. Optional BACKOFF_RETRY_CTRL_PERF_EN adds a       |
// | saturating failed-response counter on perf_retries_o.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module backoff_retry_ctrl
    import backoff_retry_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned MaxRetries = 8,
    parameter int unsigned Seed       = 'hffff,
    parameter int unsigned MaxExp     = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [DataWidth-1:0]                  req_data_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [DataWidth-1:0]                  out_data_o,
    input  logic                                  rsp_valid_i,
    input  logic                                  rsp_fail_i,
    output logic                                  done_o,
    output logic                                  done_err_o,
    output logic [retries_width(MaxRetries)-1:0]  retries_o
`ifdef BACKOFF_RETRY_CTRL_PERF_EN
    ,
    output logic [31:0]                           perf_retries_o
`endif
);

    localparam int unsigned RW = retries_width(MaxRetries);

    logic [1:0]           r_state;
    logic [DataWidth-1:0] r_data;
    logic [RW-1:0]        r_retries;
    logic                 r_done;
    logic                 r_done_err;

    logic                 w_rsp_ok;
    logic                 w_rsp_fail;
    logic                 w_last;
    logic                 w_set;
    logic                 w_clr;
    logic                 w_is_zero;
    logic [RW-1:0]        w_retries_inc;

    assign w_rsp_ok      = (r_state == ST_WAIT_RSP) && rsp_valid_i && !rsp_fail_i;
    assign w_rsp_fail    = (r_state == ST_WAIT_RSP) && rsp_valid_i &&  rsp_fail_i;
    assign w_last        = (MaxRetries != 0) && ((32'(r_retries) + 32'd1) == MaxRetries);
    assign w_set         = w_rsp_fail && !w_last;
    assign w_clr         = w_rsp_ok || (w_rsp_fail && w_last);
    assign w_retries_inc = (r_retries == '1) ? r_retries : r_retries + RW'(1);

    exp_backoff #(
        .Seed   (Seed),
        .MaxExp (MaxExp)
    ) u_exp_backoff (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .set_i     (w_set),
        .clr_i     (w_clr),
        .is_zero_o (w_is_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_retries  <= '0;
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_data    <= req_data_i;
                        r_retries <= '0;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (out_ready_i) begin
                        r_state <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (w_rsp_ok) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_rsp_fail) begin
                        r_retries <= w_retries_inc;
                        if (w_last) begin
                            r_done     <= 1'b1;
                            r_done_err <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_state <= ST_BACKOFF;
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (w_is_zero) begin
                        r_state <= ST_ISSUE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o = (r_state == ST_IDLE);
    assign out_valid_o = (r_state == ST_ISSUE);
    assign out_data_o  = r_data;
    assign done_o      = r_done;
    assign done_err_o  = r_done_err;
    assign retries_o   = r_retries;

`ifdef BACKOFF_RETRY_CTRL_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf <= '0;
        end else if (w_rsp_fail && (r_perf != 32'hffff_ffff)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_retries_o = r_perf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_backoff_retry_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_backoff_retry_ctrl                                                    |
// | Vector table, directed corner sequences and randomized transactions      |
// | against a transaction-level model. Revision: 1.0                         |
// +--------------------------------------------------------------------------+
module tb_backoff_retry_ctrl;

    localparam int unsigned DW     = 64;
    localparam int unsigned MAXR   = 3;
    localparam int unsigned MAXEXP = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_data  = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          rsp_valid = 1'b0;
    logic          rsp_fail  = 1'b0;
    logic          done;
    logic          done_err;
    logic [1:0]    retries;
`ifdef BACKOFF_RETRY_CTRL_PERF_EN
    logic [31:0]   perf;
`endif

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_sets = 0;   // backoff loads since reset = LFSR shifts taken

    backoff_retry_ctrl #(
        .DataWidth  (DW),
        .MaxRetries (MAXR),
        .Seed       ('hffff),
        .MaxExp     (MAXEXP)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .rsp_valid_i (rsp_valid),
        .rsp_fail_i  (rsp_fail),
        .done_o      (done),
        .done_err_o  (done_err),
        .retries_o   (retries)
`ifdef BACKOFF_RETRY_CTRL_PERF_EN
        ,
        .perf_retries_o (perf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // LFSR x^16+x^14+x^13+x^11 seeded 'hffff, value after n shifts
    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] v;
        v = 16'hffff;
        for (int i = 0; i < n; i++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
        return v;
    endfunction

    // Extra wait of the k-th retry: low min(k-1,MaxExp) bits of the LFSR
    function automatic int backoff_wait(input int k, input int n);
        int e;
        e = (k - 1 < int'(MAXEXP)) ? k - 1 : int'(MAXEXP);
        return ((1 << e) - 1) & int'(lfsr_after(n));
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_done",      done,      0);
        check("rst_done_err",  done_err,  0);
        check("rst_retries",   retries,   0);
`ifdef BACKOFF_RETRY_CTRL_PERF_EN
        check("rst_perf",      perf,      0);
`endif
        @(negedge clk);
        rst_n  = 1'b1;
        n_sets = 0;
    endtask

    // From an ISSUE sample: handshake, one WAIT cycle, then respond in the next one.
    task automatic handshake_respond(input logic fail);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_fail  = fail;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_fail  = 1'b0;
    endtask

    task automatic drive_vec(input logic [63:0] data, input int n_fail, output int lat,
                             output logic d, output logic e, output logic [1:0] r);
        int a;
        a = 0; d = 1'b0; e = 1'b0; r = '0;
        check("vec_idle_ready", req_ready, 1);
        req_valid = 1'b1;
        req_data  = data;
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = '0;
        lat = 1;
        while (a < 6) begin
            while (!out_valid && lat < 64) begin
                @(negedge clk);
                lat++;
            end
            check("vec_out_data", out_data, data);
            handshake_respond(a < n_fail);
            lat += 3;
            if (a < n_fail && a + 1 < int'(MAXR)) n_sets++;
            d = done; e = done_err; r = retries;
            if (done || lat >= 64) break;
            a++;
        end
    endtask

    task automatic run_txn();
        logic [63:0] data;
        int          k;
        int          w;
        bit          fail;
        bit          fin;
        data = {$urandom, $urandom};
        k = 0; fin = 0;
        check("rnd_ready", req_ready, 1);
        req_valid = 1'b1;
        req_data  = data;
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = {$urandom, $urandom};
        while (!fin) begin
            check("rnd_issue_valid", out_valid, 1);
            check("rnd_issue_data",  out_data,  data);
            check("rnd_busy_ready",  req_ready, 0);
            repeat ($urandom_range(0, 3)) begin
                rsp_valid = 1'($urandom_range(0, 1));
                rsp_fail  = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("rnd_hold_valid", out_valid, 1);
                check("rnd_hold_data",  out_data,  data);
            end
            out_ready = 1'b1;
            rsp_valid = 1'($urandom_range(0, 1));
            rsp_fail  = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            rsp_valid = 1'b0;
            check("rnd_wait_valid", out_valid, 0);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("rnd_wait_done", done, 0);
            end
            fail = ($urandom_range(0, 99) < 55);
            rsp_valid = 1'b1;
            rsp_fail  = fail;
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_fail  = 1'b0;
            if (!fail) begin
                check("rnd_ok_done", done, 1);
                check("rnd_ok_err",  done_err, 0);
                check("rnd_ok_retries", retries, 64'(k));
                fin = 1;
            end else begin
                k++;
                if (k == int'(MAXR)) begin
                    check("rnd_exh_done", done, 1);
                    check("rnd_exh_err",  done_err, 1);
                    check("rnd_exh_retries", retries, 64'(k));
                    fin = 1;
                end else begin
                    check("rnd_fail_done", done, 0);
                    check("rnd_fail_retries", retries, 64'(k));
                    check("rnd_backoff_valid", out_valid, 0);
                    w = backoff_wait(k, n_sets);
                    n_sets++;
                    repeat (w) begin
                        @(negedge clk);
                        check("rnd_backoff_valid", out_valid, 0);
                    end
                    @(negedge clk);
                end
            end
        end
        @(negedge clk);
        check("rnd_done_pulse", done, 0);
        check("rnd_idle_ready", req_ready, 1);
        repeat ($urandom_range(0, 2)) begin
            rsp_valid = 1'($urandom_range(0, 1));
            rsp_fail  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rnd_idle_valid", out_valid, 0);
        end
        rsp_valid = 1'b0;
        rsp_fail  = 1'b0;
    endtask

    typedef struct {
        logic [63:0] data;
        int          n_fail;
        logic        exp_err;
        logic [1:0]  exp_ret;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t        vecs[4];
        int          lat;
        logic        d;
        logic        e;
        logic [1:0]  r;
        logic [63:0] bp_data;

        // Latency = samples from request to done: 1 + 3 per attempt + (1 + wait) per retry
        vecs[0] = '{64'h1234,                0, 1'b0, 2'd0, 4};
        vecs[1] = '{64'ha5a5_5a5a_0f0f_f0f0, 1, 1'b0, 2'd1, 8};
        vecs[2] = '{64'hdead_beef_cafe_f00d, 2, 1'b0, 2'd2, 13};
        vecs[3] = '{64'h0123_4567_89ab_cdef, 3, 1'b1, 2'd3, 13};

        #2;
        do_reset();

        for (int i = 0; i < 4; i++) begin
            drive_vec(vecs[i].data, vecs[i].n_fail, lat, d, e, r);
            check($sformatf("vec%0d_done", i),    d,   1);
            check($sformatf("vec%0d_err", i),     e,   vecs[i].exp_err);
            check($sformatf("vec%0d_retries", i), r,   vecs[i].exp_ret);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), done, 0);
        end
        repeat (4) begin
            @(negedge clk);
            check("exh_no_reissue", out_valid, 0);
        end
        check("exh_idle_ready", req_ready, 1);

        // Backpressure with spurious responses while issuing
        bp_data   = 64'h5a5a_1234_8765_a5a5;
        req_valid = 1'b1;
        req_data  = bp_data;
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = '1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data",  out_data,  bp_data);
            rsp_valid = 1'b1;
            rsp_fail  = i[0];
            @(negedge clk);
        end
        check("bp_valid_end", out_valid, 1);
        check("bp_no_done",   done,      0);
        out_ready = 1'b1;
        rsp_valid = 1'b1;
        rsp_fail  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_fail  = 1'b0;
        check("bp_hs_ignored_rsp", retries, 0);
        check("bp_wait_valid",     out_valid, 0);
        @(negedge clk);
        rsp_valid = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("bp_done",    done,     1);
        check("bp_err",     done_err, 0);
        check("bp_retries", retries,  0);
        @(negedge clk);

        // Reset in the middle of the second backoff
        do_reset();
        req_valid = 1'b1;
        req_data  = 64'hfeed;
        @(negedge clk);
        req_valid = 1'b0;
        handshake_respond(1'b1);
        check("mid_bo1_valid", out_valid, 0);
        @(negedge clk);
        check("mid_reissue1", out_valid, 1);
        handshake_respond(1'b1);
        check("mid_bo2_valid",   out_valid, 0);
        check("mid_bo2_retries", retries,   2);
        check("mid_bo2_done",    done,      0);
`ifdef BACKOFF_RETRY_CTRL_PERF_EN
        check("mid_perf_before", perf, 2);
`endif
        do_reset();
        n_sets = 0;
        drive_vec(64'h0bad_f00d, 2, lat, d, e, r);
        check("post_rst_done",    d,   1);
        check("post_rst_err",     e,   0);
        check("post_rst_retries", r,   2);
        check("post_rst_latency", lat, 13);
`ifdef BACKOFF_RETRY_CTRL_PERF_EN
        check("post_rst_perf", perf, 2);
`endif
        @(negedge clk);

        for (int t = 0; t < 40; t++) run_txn();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
